// File: rtl/lsu_if.sv
// Execute-stage request, writeback response and memory port bundle for the lsu.
// slave is the lsu side; master is the requester/memory side.
interface lsu_if #(
  parameter int ADDR_W = 8,
  parameter int XLEN   = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_base;
  logic [11:0]       req_offset;
  logic [XLEN-1:0]   req_wdata;
  logic [4:0]        req_rd;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic [4:0]        rsp_rd;
  logic              rsp_fault;

  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_rw;
  logic [2:0]        mem_funct3;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_base, req_offset, req_wdata, req_rd,
    input  rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_fault,
    output mem_addr, mem_wdata, mem_rw, mem_funct3
  );

  modport master (
    output req_valid, req_we, req_funct3, req_base, req_offset, req_wdata, req_rd,
    output rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_fault,
    input  mem_addr, mem_wdata, mem_rw, mem_funct3
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: effective-address generation and checking, a single-cycle
// memory access, load extension and a valid/ready response to writeback.
module lsu #(
  parameter int ADDR_W = 8,
  parameter int XLEN   = 32
) (
  input  logic i_clk,
  input  logic i_rst,
  lsu_if.slave io_bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_we;
  logic [2:0]        r_funct3;
  logic [4:0]        r_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [XLEN-1:0]   r_mem_wdata;
  logic [2:0]        r_mem_funct3;
  logic              r_mem_rw;
  logic [XLEN-1:0]   r_rsp_rdata;
  logic [4:0]        r_rsp_rd;
  logic              r_rsp_fault;

  logic [XLEN-1:0]   w_ea;
  logic              w_range_err;
  logic              w_fn_err;
  logic              w_fault;
  logic              w_req_ready;
  logic              w_accept;

  function automatic logic [XLEN-1:0] f_extend(input logic [2:0] f3, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] v;
    case (f3)
      3'b000:  v = {{(XLEN-8){d[7]}}, d[7:0]};
      3'b100:  v = {{(XLEN-8){1'b0}}, d[7:0]};
      3'b001:  v = {{(XLEN-16){d[15]}}, d[15:0]};
      3'b101:  v = {{(XLEN-16){1'b0}}, d[15:0]};
      default: v = d;
    endcase
    return v;
  endfunction

  assign w_ea        = io_bus.req_base + {{(XLEN-12){io_bus.req_offset[11]}}, io_bus.req_offset};
  assign w_range_err = |w_ea[XLEN-1:ADDR_W];
  assign w_req_ready = (r_state == S_IDLE) | ((r_state == S_RESP) & io_bus.rsp_ready);
  assign w_accept    = io_bus.req_valid & w_req_ready;
  assign w_fault     = w_range_err | w_fn_err;

  // Alignment and funct3 legality; bu/hu exist only as loads.
  always_comb begin
    w_fn_err = 1'b1;
    case (io_bus.req_funct3)
      3'b000:  w_fn_err = 1'b0;
      3'b001:  w_fn_err = w_ea[0];
      3'b010:  w_fn_err = |w_ea[1:0];
      3'b100:  w_fn_err = io_bus.req_we;
      3'b101:  w_fn_err = io_bus.req_we | w_ea[0];
      default: w_fn_err = 1'b1;
    endcase
  end

  // Next-state logic; a handshake in RESP may start the next request on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_fault ? S_RESP : S_ACCESS;
        else          w_state_nxt = S_IDLE;
      end
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP: begin
        if (w_accept)              w_state_nxt = w_fault ? S_RESP : S_ACCESS;
        else if (io_bus.rsp_ready) w_state_nxt = S_IDLE;
        else                       w_state_nxt = S_RESP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Request capture, memory drive and response capture; memory lines hold across faults.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we         <= 1'b0;
      r_funct3     <= 3'b000;
      r_rd         <= 5'd0;
      r_mem_addr   <= {ADDR_W{1'b0}};
      r_mem_wdata  <= {XLEN{1'b0}};
      r_mem_funct3 <= 3'b000;
      r_mem_rw     <= 1'b0;
      r_rsp_rdata  <= {XLEN{1'b0}};
      r_rsp_rd     <= 5'd0;
      r_rsp_fault  <= 1'b0;
    end else begin
      r_mem_rw <= 1'b0;
      if (w_accept) begin
        r_we     <= io_bus.req_we;
        r_funct3 <= io_bus.req_funct3;
        r_rd     <= io_bus.req_rd;
        if (w_fault) begin
          r_rsp_fault <= 1'b1;
          r_rsp_rdata <= {XLEN{1'b0}};
          r_rsp_rd    <= 5'd0;
        end else begin
          r_mem_addr   <= w_ea[ADDR_W-1:0];
          r_mem_wdata  <= io_bus.req_wdata;
          r_mem_funct3 <= {1'b0, io_bus.req_funct3[1:0]};
          r_mem_rw     <= io_bus.req_we;
        end
      end else if (r_state == S_ACCESS) begin
        r_rsp_fault <= 1'b0;
        r_rsp_rdata <= r_we ? {XLEN{1'b0}} : f_extend(r_funct3, io_bus.mem_rdata);
        r_rsp_rd    <= r_we ? 5'd0 : r_rd;
      end else begin
        r_rsp_fault <= r_rsp_fault;
      end
    end
  end

  assign io_bus.req_ready  = w_req_ready;
  assign io_bus.rsp_valid  = (r_state == S_RESP);
  assign io_bus.rsp_rdata  = r_rsp_rdata;
  assign io_bus.rsp_rd     = r_rsp_rd;
  assign io_bus.rsp_fault  = r_rsp_fault;
  assign io_bus.mem_addr   = r_mem_addr;
  assign io_bus.mem_wdata  = r_mem_wdata;
  assign io_bus.mem_rw     = r_mem_rw;
  assign io_bus.mem_funct3 = r_mem_funct3;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: byte memory driven by the DUT's memory port, and a
// reference byte array updated by a request-level model of the load/store rules.
module tb_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [7:0]  tb_mem  [0:255];
  logic [7:0]  ref_mem [0:255];
  logic [31:0] obs_rdata;

  lsu_if #(.ADDR_W(8), .XLEN(32)) bus ();
  lsu #(.ADDR_W(8), .XLEN(32)) dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));

  always #5 clk = ~clk;

  logic [7:0] a0, a1, a2, a3;
  assign a0 = bus.mem_addr;
  assign a1 = bus.mem_addr + 8'd1;
  assign a2 = bus.mem_addr + 8'd2;
  assign a3 = bus.mem_addr + 8'd3;
  assign bus.mem_rdata = bus.mem_rw ? 32'h0 : {tb_mem[a3], tb_mem[a2], tb_mem[a1], tb_mem[a0]};

  // Memory: bulk load from the reference copy, otherwise width-strobed writes.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= ref_mem[i];
    end else if (bus.mem_rw) begin
      tb_mem[a0] <= bus.mem_wdata[7:0];
      if (bus.mem_funct3 != 3'b000) tb_mem[a1] <= bus.mem_wdata[15:8];
      if (bus.mem_funct3 == 3'b010) begin
        tb_mem[a2] <= bus.mem_wdata[23:16];
        tb_mem[a3] <= bus.mem_wdata[31:24];
      end
    end
  end

  // Request-level reference: computes ea, fault, and response; applies stores to ref_mem.
  task automatic model(input bit we, input bit [2:0] f3, input bit [31:0] base, input bit [11:0] off,
                       input bit [31:0] wdata, input bit [4:0] rd,
                       output bit fault, output bit [31:0] rdata, output bit [4:0] rdo, output bit [31:0] ea);
    int  size;
    bit  legal;
    ea    = base + {{20{off[11]}}, off};
    size  = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    fault = !legal || (ea > 32'd255) || ((ea % size) != 0);
    rdata = 32'h0;
    rdo   = 5'd0;
    if (!fault) begin
      if (we) begin
        for (int i = 0; i < size; i++) ref_mem[int'(ea) + i] = 8'(wdata >> (8 * i));
      end else begin
        for (int i = 0; i < size; i++) rdata = rdata | (32'(ref_mem[int'(ea) + i]) << (8 * i));
        if ((f3 == 3'd0 || f3 == 3'd1) && rdata[8 * size - 1]) rdata = rdata - (32'd1 << (8 * size));
        rdo = rd;
      end
    end
  endtask

  task automatic drive(input bit we, input bit [2:0] f3, input bit [31:0] base, input bit [11:0] off,
                       input bit [31:0] wdata, input bit [4:0] rd);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_base   = base;
    bus.req_offset = off;
    bus.req_wdata  = wdata;
    bus.req_rd     = rd;
  endtask

  // One request from IDLE with rsp_ready high; checks memory port and response timing.
  task automatic issue(input bit we, input bit [2:0] f3, input bit [31:0] base, input bit [11:0] off,
                       input bit [31:0] wdata, input bit [4:0] rd, input string nm);
    bit ef; bit [31:0] er; bit [4:0] erd; bit [31:0] ea;
    model(we, f3, base, off, wdata, rd, ef, er, erd, ea);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    drive(we, f3, base, off, wdata, rd);
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL %s.req_ready got=%b exp=1", nm, bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (!ef) begin
      checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL %s.access_rsp_valid got=%b exp=0", nm, bus.rsp_valid); end
      checks++; if (bus.mem_rw !== we) begin failures++; $display("FAIL %s.mem_rw got=%b exp=%b", nm, bus.mem_rw, we); end
      checks++; if (bus.mem_addr !== ea[7:0]) begin failures++; $display("FAIL %s.mem_addr got=%h exp=%h", nm, bus.mem_addr, ea[7:0]); end
      checks++; if (bus.mem_wdata !== wdata) begin failures++; $display("FAIL %s.mem_wdata got=%h exp=%h", nm, bus.mem_wdata, wdata); end
      checks++; if (bus.mem_funct3 !== {1'b0, f3[1:0]}) begin failures++; $display("FAIL %s.mem_funct3 got=%b exp=%b", nm, bus.mem_funct3, {1'b0, f3[1:0]}); end
      @(negedge clk);
    end
    checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL %s.rsp_valid got=%b exp=1", nm, bus.rsp_valid); end
    checks++; if (bus.rsp_fault !== ef) begin failures++; $display("FAIL %s.rsp_fault got=%b exp=%b", nm, bus.rsp_fault, ef); end
    checks++; if (bus.rsp_rdata !== er) begin failures++; $display("FAIL %s.rsp_rdata got=%h exp=%h", nm, bus.rsp_rdata, er); end
    checks++; if (bus.rsp_rd !== erd) begin failures++; $display("FAIL %s.rsp_rd got=%0d exp=%0d", nm, bus.rsp_rd, erd); end
    checks++; if (bus.mem_rw !== 1'b0) begin failures++; $display("FAIL %s.resp_mem_rw got=%b exp=0", nm, bus.mem_rw); end
    obs_rdata = bus.rsp_rdata;
  endtask

  task automatic check_mem(input string nm);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL %s.memory got=%0d differing bytes exp=0", nm, bad); end
  endtask

  task automatic check_reset_values(input string nm);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL %s.req_ready got=%b exp=1", nm, bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL %s.rsp_valid got=%b exp=0", nm, bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL %s.rsp_rdata got=%h exp=0", nm, bus.rsp_rdata); end
    checks++; if (bus.rsp_rd !== 5'd0) begin failures++; $display("FAIL %s.rsp_rd got=%0d exp=0", nm, bus.rsp_rd); end
    checks++; if (bus.rsp_fault !== 1'b0) begin failures++; $display("FAIL %s.rsp_fault got=%b exp=0", nm, bus.rsp_fault); end
    checks++; if (bus.mem_addr !== 8'h0) begin failures++; $display("FAIL %s.mem_addr got=%h exp=0", nm, bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0) begin failures++; $display("FAIL %s.mem_wdata got=%h exp=0", nm, bus.mem_wdata); end
    checks++; if (bus.mem_rw !== 1'b0) begin failures++; $display("FAIL %s.mem_rw got=%b exp=0", nm, bus.mem_rw); end
    checks++; if (bus.mem_funct3 !== 3'b000) begin failures++; $display("FAIL %s.mem_funct3 got=%b exp=000", nm, bus.mem_funct3); end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 12'h0, 32'h0, 5'd0);
    bus.req_valid = 1'b0;
    mem_init = 1'b1;
    repeat (2) @(negedge clk);
    mem_init = 1'b0;
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("after_release");
  endtask

  task automatic test_word();
    issue(1'b1, 3'b010, 32'h10, 12'h000, 32'hDEADBEEF, 5'd9, "sw_0x10");
    issue(1'b0, 3'b010, 32'h10, 12'h000, 32'h0, 5'd5, "lw_0x10");
    checks++; if (obs_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_const got=%h exp=deadbeef", obs_rdata); end
  endtask

  task automatic test_extension();
    issue(1'b1, 3'b000, 32'h20, 12'h000, 32'h12345680, 5'd1, "sb_0x20");
    issue(1'b1, 3'b001, 32'h22, 12'h000, 32'hABCD8001, 5'd1, "sh_0x22");
    issue(1'b0, 3'b000, 32'h20, 12'h000, 32'h0, 5'd2, "lb_0x20");
    checks++; if (obs_rdata !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_const got=%h exp=ffffff80", obs_rdata); end
    issue(1'b0, 3'b100, 32'h20, 12'h000, 32'h0, 5'd3, "lbu_0x20");
    checks++; if (obs_rdata !== 32'h00000080) begin failures++; $display("FAIL lbu_const got=%h exp=00000080", obs_rdata); end
    issue(1'b0, 3'b001, 32'h22, 12'h000, 32'h0, 5'd4, "lh_0x22");
    checks++; if (obs_rdata !== 32'hFFFF8001) begin failures++; $display("FAIL lh_const got=%h exp=ffff8001", obs_rdata); end
    issue(1'b0, 3'b101, 32'h22, 12'h000, 32'h0, 5'd6, "lhu_0x22");
    checks++; if (obs_rdata !== 32'h00008001) begin failures++; $display("FAIL lhu_const got=%h exp=00008001", obs_rdata); end
  endtask

  task automatic test_offset();
    issue(1'b0, 3'b010, 32'h40, 12'hFFC, 32'h0, 5'd7, "lw_neg_offset");
    checks++; if (bus.mem_addr !== 8'h3C) begin failures++; $display("FAIL neg_offset_addr got=%h exp=3c", bus.mem_addr); end
    issue(1'b1, 3'b000, 32'hFF, 12'h001, 32'h55, 5'd7, "sb_out_of_range");
    issue(1'b0, 3'b000, 32'hFF, 12'h000, 32'h0, 5'd8, "lb_top_byte");
  endtask

  task automatic test_illegal();
    issue(1'b0, 3'b001, 32'h11, 12'h000, 32'h0, 5'd3, "lh_misaligned");
    issue(1'b1, 3'b010, 32'h12, 12'h000, 32'hCAFEF00D, 5'd3, "sw_misaligned");
    issue(1'b0, 3'b011, 32'h10, 12'h000, 32'h0, 5'd3, "load_f3_011");
    issue(1'b1, 3'b100, 32'h10, 12'h000, 32'h77, 5'd3, "store_f3_100");
    check_mem("illegal");
  endtask

  task automatic test_backpressure();
    bit ef; bit [31:0] er, ea; bit [4:0] erd;
    bit ef2; bit [31:0] er2, ea2; bit [4:0] erd2;
    model(1'b0, 3'b010, 32'h10, 12'h0, 32'h0, 5'd7, ef, er, erd, ea);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive(1'b0, 3'b010, 32'h10, 12'h0, 32'h0, 5'd7);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    model(1'b0, 3'b100, 32'h20, 12'h0, 32'h0, 5'd3, ef2, er2, erd2, ea2);
    drive(1'b0, 3'b100, 32'h20, 12'h0, 32'h0, 5'd3);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== er || bus.rsp_rd !== erd || bus.rsp_fault !== 1'b0) begin
        failures++; $display("FAIL bp_hold[%0d] got=%b/%h/%0d/%b exp=1/%h/%0d/0", c, bus.rsp_valid, bus.rsp_rdata, bus.rsp_rd, bus.rsp_fault, er, erd);
      end
      checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL bp_req_ready[%0d] got=%b exp=0", c, bus.req_ready); end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.mem_addr !== ea2[7:0]) begin
      failures++; $display("FAIL bp_same_edge_accept got=%b/%h exp=0/%h", bus.rsp_valid, bus.mem_addr, ea2[7:0]);
    end
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== er2 || bus.rsp_rd !== erd2) begin
      failures++; $display("FAIL bp_second_rsp got=%b/%h/%0d exp=1/%h/%0d", bus.rsp_valid, bus.rsp_rdata, bus.rsp_rd, er2, erd2);
    end
  endtask

  task automatic test_back_to_back();
    bit we; bit [2:0] f3; bit [31:0] base, wdata; bit [11:0] off; bit [4:0] rd;
    bit ef; bit [31:0] er, ea; bit [4:0] erd;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      we    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      base  = 32'($urandom_range(0, 270));
      off   = 12'($urandom_range(0, 31)) - 12'd16;
      wdata = $urandom;
      rd    = 5'($urandom);
      model(we, f3, base, off, wdata, rd, ef, er, erd, ea);
      drive(we, f3, base, off, wdata, rd);
      #1;
      checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL b2b[%0d].req_ready got=%b exp=1", k, bus.req_ready); end
      @(negedge clk);
      if (!ef) begin
        checks++; if (bus.rsp_valid !== 1'b0 || bus.mem_rw !== we || bus.mem_addr !== ea[7:0]) begin
          failures++; $display("FAIL b2b[%0d].access got=%b/%b/%h exp=0/%b/%h", k, bus.rsp_valid, bus.mem_rw, bus.mem_addr, we, ea[7:0]);
        end
        @(negedge clk);
      end
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_fault !== ef || bus.rsp_rdata !== er || bus.rsp_rd !== erd) begin
        failures++; $display("FAIL b2b[%0d].rsp got=%b/%b/%h/%0d exp=1/%b/%h/%0d", k, bus.rsp_valid, bus.rsp_fault, bus.rsp_rdata, bus.rsp_rd, ef, er, erd);
      end
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b.drain got=%b exp=0", bus.rsp_valid); end
    check_mem("b2b");
  endtask

  task automatic test_reset_mid();
    bit ef; bit [31:0] er, ea; bit [4:0] erd;
    model(1'b0, 3'b010, 32'h10, 12'h0, 32'h0, 5'd11, ef, er, erd, ea);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    drive(1'b0, 3'b010, 32'h10, 12'h0, 32'h0, 5'd11);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_values("rst_in_access");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_no_rsp[%0d] got=%b exp=0", c, bus.rsp_valid); end
    end
    issue(1'b0, 3'b010, 32'h10, 12'h0, 32'h0, 5'd12, "lw_after_rst");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_word();
    test_extension();
    test_offset();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
